// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake between the host, the TX FIFO and the UART transmitter.
// The host drives the i_* write side and the transmitter drives i_ready. The FIFO
// drives o_ready, o_data and o_valid.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter. It has registered
// flags, a registered head byte on o_data and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus,
  input  logic          i_flush,
  input  logic          i_clr_ovf,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [AW:0]       count_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              push;
  logic              pop;
  logic              ovf_set;

  assign push    = bus.i_valid & bus.o_ready & ~i_flush;
  assign pop     = bus.o_valid & bus.i_ready & ~i_flush;
  assign ovf_set = bus.i_valid & o_full;

  // The next head is normally in memory. It is the incoming byte only when that byte
  // lands exactly where the read pointer is heading: an empty FIFO, or its last entry being popped.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = o_count;
    head_nxt   = mem[rd_ptr];
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
    if (push && !pop) begin
      count_nxt = o_count + CNT_ONE;
    end else if (pop && !push) begin
      count_nxt = o_count - CNT_ONE;
    end
    if (push && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = bus.i_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      bus.o_ready <= 1'b1;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      o_ovf       <= 1'b0;
    end else begin
      o_ovf <= ovf_set | (o_ovf & ~i_clr_ovf);
      if (i_flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        o_count     <= '0;
        o_full      <= 1'b0;
        o_empty     <= 1'b1;
        bus.o_ready <= 1'b1;
        bus.o_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        rd_ptr      <= rd_ptr_nxt;
        o_count     <= count_nxt;
        o_full      <= (count_nxt == CNT_FULL);
        o_empty     <= (count_nxt == CNT_ZERO);
        bus.o_ready <= (count_nxt != CNT_FULL);
        bus.o_valid <= (count_nxt != CNT_ZERO);
        if (count_nxt != CNT_ZERO) begin
          bus.o_data <= head_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. It covers ordering, full/overflow, concurrent
// push+pop with wrap, FWFT latency, flush and mid-operation reset.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       i_flush;
  logic       i_clr_ovf;
  logic [4:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_ovf;
  int         num_checks;
  int         num_fails;

  uart_tx_fifo_if #(.DATA_W(8)) bus ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .i_flush   (i_flush),
    .i_clr_ovf (i_clr_ovf),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_empty   (o_empty),
    .o_ovf     (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of handshake inputs, then settle just after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_count", 32'(o_count), 0);
    checkOutput("rst_valid", 32'(bus.o_valid), 0);
    checkOutput("rst_ready", 32'(bus.o_ready), 1);
    checkOutput("rst_empty", 32'(o_empty), 1);
    checkOutput("rst_full", 32'(o_full), 0);
    checkOutput("rst_ovf", 32'(o_ovf), 0);
    checkOutput("rst_data", 32'(bus.o_data), 0);
  endtask

  initial begin
    num_checks  = 0;
    num_fails   = 0;
    rst         = 1'b0;
    i_flush     = 1'b0;
    i_clr_ovf   = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_ready = 1'b0;
    applyStimulus(1'b1, 8'hAA, 1'b1);
    rst = 1'b1;
    checkReset();

    // Three bytes are buffered, then drained one per clock.
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0);
    bus.i_valid = 1'b0;
    checkOutput("t1_count", 32'(o_count), 3);
    checkOutput("t1_valid", 32'(bus.o_valid), 1);
    checkOutput("t1_head", 32'(bus.o_data), 32'h41);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_drain", 32'(bus.o_data), 32'h41 + k);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("t1_empty", 32'(o_empty), 1);

    // Fill to the brim, overflow once, drain and clear the sticky flag.
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 8'(k), 1'b0);
    checkOutput("t2_full", 32'(o_full), 1);
    checkOutput("t2_ready", 32'(bus.o_ready), 0);
    checkOutput("t2_ovf_pre", 32'(o_ovf), 0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("t2_ovf", 32'(o_ovf), 1);
    checkOutput("t2_count", 32'(o_count), 16);
    for (int k = 0; k < 16; k++) begin
      checkOutput("t2_dvalid", 32'(bus.o_valid), 1);
      checkOutput("t2_drain", 32'(bus.o_data), 32'(k));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("t2_empty", 32'(o_empty), 1);
    checkOutput("t2_ovf_kept", 32'(o_ovf), 1);
    i_clr_ovf = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    i_clr_ovf = 1'b0;
    checkOutput("t2_ovf_clr", 32'(o_ovf), 0);

    // Concurrent push and pop at count 5 across two pointer wraps.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 8'h80 + 8'(k), 1'b0);
    for (int k = 0; k < 40; k++) begin
      checkOutput("t3_count", 32'(o_count), 5);
      checkOutput("t3_data", 32'(bus.o_data), 32'h80 + k);
      applyStimulus(1'b1, 8'h85 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("t3_tail", 32'(bus.o_data), 32'hA8 + k);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("t3_empty", 32'(o_empty), 1);

    // Push into an empty FIFO with ready high: no same-cycle pop.
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("t4_valid", 32'(bus.o_valid), 1);
    checkOutput("t4_data", 32'(bus.o_data), 32'h5A);
    checkOutput("t4_count", 32'(o_count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t4_empty", 32'(o_empty), 1);

    // Flush discards contents and the write in the flush cycle.
    for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 8'(k), 1'b0);
    checkOutput("t5_count_pre", 32'(o_count), 7);
    i_flush = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b1);
    i_flush = 1'b0;
    checkOutput("t5_count", 32'(o_count), 0);
    checkOutput("t5_valid", 32'(bus.o_valid), 0);
    checkOutput("t5_ready", 32'(bus.o_ready), 1);
    applyStimulus(1'b1, 8'h12, 1'b0);
    checkOutput("t5_data", 32'(bus.o_data), 32'h12);
    checkOutput("t5_count1", 32'(o_count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t5_empty", 32'(o_empty), 1);

    // Overflow, drain to 9, then reset in the middle of draining.
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 8'h30 + 8'(k), 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_count9", 32'(o_count), 9);
    checkOutput("t6_ovf", 32'(o_ovf), 1);
    checkOutput("t6_head", 32'(bus.o_data), 32'h37);
    applyStimulus(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h55, 1'b1);
    rst = 1'b1;
    checkReset();
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("t6_post_data", 32'(bus.o_data), 32'h77);
    checkOutput("t6_post_count", 32'(o_count), 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_post_empty", 32'(o_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
